// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencing controller and its MISR.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] MISR_TAPS     = 8'b1000_1110;
    localparam logic [7:0] DEF_MISR_SEED = 8'h00;
    localparam int         DEF_CHAIN_LEN = 8;

    // One MISR step: feedback from the tap positions, serial response folded into bit 0.
    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic din);
        return {m[6:0], (^(m & MISR_TAPS)) ^ din};
    endfunction

endpackage

// File: rtl/bist_if.sv
// Control/status bundle between the self-test wrapper and the BIST controller.
interface bist_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             abort;
    logic             scan_data_in;
    logic             scan_en;
    logic             lfsr_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       signature;
    logic [CNT_W-1:0] pattern_cnt;

    modport master (
        output start, abort, scan_data_in,
        input  scan_en, lfsr_en, busy, done, pass, signature, pattern_cnt
    );

    modport slave (
        input  start, abort, scan_data_in,
        output scan_en, lfsr_en, busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/bist_misr.sv
// 8-bit multiple-input signature register with seed load; reusable across self-test wrappers.
module bist_misr
    import bist_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_en,
    input  logic       i_din,
    output logic [7:0] o_sig
);

    logic [7:0] r_sig;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sig <= i_seed;
        end else if (i_load) begin
            r_sig <= i_seed;
        end else if (i_en) begin
            r_sig <= misr_step(r_sig, i_din);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: IDLE -> (SHIFT, CAPTURE) x NUM_PATTERNS -> UNLOAD -> DRAIN -> DONE.
// Sole source of scan_en; compacts the delayed scan response into the MISR.
module bist_controller
    import bist_pkg::*;
#(
    parameter int         CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int         NUM_PATTERNS = 16,
    parameter logic [7:0] GOLDEN       = 8'h00,
    parameter logic [7:0] MISR_SEED    = DEF_MISR_SEED
) (
    input  logic  i_clk,
    input  logic  i_rst,
    bist_if.slave bus
);

    localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam int               BIT_W    = $clog2(CHAIN_LEN);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PAT_MAX  = CNT_W'(NUM_PATTERNS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_pattern_cnt;
    logic             r_scan_en;
    logic             r_lfsr_en;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_misr_en;

    logic             w_scan_en_nxt;
    logic             w_lfsr_en_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic             w_start_run;
    logic             w_bit_last;
    logic             w_compact;
    logic             w_misr_step;
    logic [7:0]       w_sig;
    logic [7:0]       w_sig_nxt;

    assign w_start_run = bus.start && !bus.abort && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_bit_last  = (r_bit_cnt == BIT_LAST);
    // The first SHIFT only flushes stale chain contents, so it is never compacted.
    assign w_compact   = r_scan_en && (r_state == ST_UNLOAD ||
                                       (r_state == ST_SHIFT && r_pattern_cnt != '0));
    assign w_misr_step = r_misr_en && !bus.abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_scan_en     <= 1'b1;
            r_lfsr_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_bit_cnt     <= '0;
            r_pattern_cnt <= '0;
            r_misr_en     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_scan_en <= w_scan_en_nxt;
            r_lfsr_en <= w_lfsr_en_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_misr_en <= bus.abort ? 1'b0 : w_compact;

            if (bus.abort) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT || r_state == ST_UNLOAD) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            end

            if (bus.abort || w_start_run) begin
                r_pattern_cnt <= '0;
            end else if (w_state_nxt == ST_CAPTURE && r_pattern_cnt < PAT_MAX) begin
                r_pattern_cnt <= r_pattern_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (bus.start) w_state_nxt = ST_SHIFT;
                ST_SHIFT:   if (w_bit_last) w_state_nxt = ST_CAPTURE;
                // pattern_cnt already includes the capture in progress
                ST_CAPTURE: w_state_nxt = (r_pattern_cnt >= PAT_MAX) ? ST_UNLOAD : ST_SHIFT;
                ST_UNLOAD:  if (w_bit_last) w_state_nxt = ST_DRAIN;
                ST_DRAIN:   w_state_nxt = ST_DONE;
                ST_DONE:    if (bus.start) w_state_nxt = ST_SHIFT;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_scan_en_nxt = (w_state_nxt != ST_CAPTURE);
        w_lfsr_en_nxt = (w_state_nxt == ST_SHIFT);
        w_busy_nxt    = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_CAPTURE) ||
                        (w_state_nxt == ST_UNLOAD) || (w_state_nxt == ST_DRAIN);
        w_done_nxt    = (w_state_nxt == ST_DONE);
        w_sig_nxt     = w_misr_step ? misr_step(w_sig, bus.scan_data_in) : w_sig;
        w_pass_nxt    = (w_state_nxt == ST_DONE) && (w_sig_nxt == GOLDEN);
    end

    bist_misr u_misr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_start_run),
        .i_seed (MISR_SEED),
        .i_en   (w_misr_step),
        .i_din  (bus.scan_data_in),
        .o_sig  (w_sig)
    );

    assign bus.scan_en     = r_scan_en;
    assign bus.lfsr_en     = r_lfsr_en;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.signature   = w_sig;
    assign bus.pattern_cnt = r_pattern_cnt;

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Sequencing controller for the built-in self-test loop: LFSR pattern source → 8-bit scan chain → response compactor.
- Drives the scan chain's scan_en and the LFSR advance enable through NUM_PATTERNS shift/capture rounds, then a final unload.
- Compacts the serial scan response into an internal MISR and compares the signature against a golden value.
- Sits beside the LFSR and scan chain inside the self-test wrapper; it is the only source of scan_en.

Parameters:
CHAIN_LEN, 8, scan chain length in bits (shift cycles per pattern), ≥2
NUM_PATTERNS, 16, number of patterns loaded and captured per run, ≥1
GOLDEN, 8'h00, expected final MISR signature
MISR_SEED, 8'h00, MISR value loaded on start

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin run; sampled only in IDLE
abort  input  1  cancel run; returns to IDLE next edge
scan_data_in  input  1  registered serial response from scan chain (scan_out)
scan_en  output  1  to scan chain: 1 = shift, 0 = capture
lfsr_en  output  1  advance enable for pattern LFSR
busy  output  1  run in progress
done  output  1  run finished; held until next start/abort/rst
pass  output  1  signature == GOLDEN; valid while done=1, else 0
signature  output  8  current MISR contents
pattern_cnt  output  $clog2(NUM_PATTERNS+1)  patterns captured so far

Behaviour:
Reset:
- Clock, reset: clk and rst. rst is synchronous, active-high.
- On rst: state=IDLE, scan_en=1, lfsr_en=0, busy=0, done=0, pass=0, signature=MISR_SEED, pattern_cnt=0, bit counter=0, misr_en pipe=0.
- scan_en idles at 1 so the chain never captures while idle.

States: IDLE, SHIFT, CAPTURE, UNLOAD, DRAIN, DONE; all outputs registered.
- IDLE: start=1 → SHIFT. Load MISR_SEED, clear pattern_cnt and done/pass.
- SHIFT: scan_en=1, lfsr_en=1 for CHAIN_LEN cycles (bit counter 0..CHAIN_LEN-1), then → CAPTURE.
- CAPTURE: one cycle, scan_en=0, lfsr_en=0. pattern_cnt increments.
  - pattern_cnt reaching NUM_PATTERNS → UNLOAD.
  - otherwise → SHIFT.
- UNLOAD: scan_en=1, lfsr_en=0 for CHAIN_LEN cycles, flushing the last capture, then → DRAIN.
- DRAIN: one cycle, scan_en=1. Absorbs the final delayed response bit, then → DONE.
- DONE: done=1, pass=(MISR==GOLDEN) latched on entry. start → restart as from IDLE.
- busy=1 in SHIFT, CAPTURE, UNLOAD and DRAIN only.

Compaction:
- compact = scan_en & (state==UNLOAD | (state==SHIFT & pattern_cnt≥1)). The first SHIFT only flushes reset contents and is never compacted.
- misr_en is compact delayed one cycle, matching the chain's registered scan_out.
- When misr_en=1: fb = m[7]^m[3]^m[2]^m[1]; m_next = {m[6:0], fb ^ scan_data_in}.
- Total compacted bits = NUM_PATTERNS·CHAIN_LEN.

Latency:
- start sampled at edge k → first SHIFT cycle at k+1.
- done=1 from k + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 2.

Boundary conditions:
- start while busy: ignored.
- abort (any state): next edge → IDLE with reset values, except signature, which holds for debug. abort has priority over start.
- rst mid-run: full reset values.
- NUM_PATTERNS=1: SHIFT → CAPTURE → UNLOAD directly; compaction only in UNLOAD.
- pattern_cnt saturates at NUM_PATTERNS; the bit counter wraps to 0 on every SHIFT/UNLOAD exit.

Decomposition:
- Shared package bist_pkg holds:
  - state enum (IDLE..DONE)
  - MISR tap constant 8'b1000_1110
  - default MISR_SEED
  - default CHAIN_LEN
- One sub-module, bist_misr: 8-bit MISR with clk, rst, load, seed, en, din, sig. It is reusable for other self-test wrappers.
- The FSM and counters stay in bist_controller.

Test Plan:
1. CHAIN_LEN=8, NUM_PATTERNS=4, GOLDEN=0, scan_data_in tied 0, start at cycle 0 → busy from cycle 1; scan_en low exactly on cycles 9,18,27,36; done=1 at cycle 46; signature=8'h00, pass=1, pattern_cnt=4.
2. Same config, scan_data_in tied 1 → misr_en asserted exactly 32 cycles; signature equals the reference-model value (nonzero); pass=0.
3. Full loop with LFSR (seed 8'hBD) and scan chain, default params, GOLDEN from behavioural model → pass=1. Flip one injected response bit → pass=0.
4. abort at cycle 20 of a run → IDLE at 21: busy=0, done=0, scan_en=1, lfsr_en=0. New start then completes normally with the case-1 timing.
5. start pulsed at cycles 5 and 30 during a run → ignored; done timing unchanged. rst asserted at cycle 12 → all reset values at 13, signature=MISR_SEED.
6. NUM_PATTERNS=1, CHAIN_LEN=8 → single CAPTURE at cycle 9; UNLOAD cycles 10-17; DRAIN 18; done at 19; misr_en asserted 8 cycles.
